// File: rtl/tube_r3_dma_ctrl.sv
// Parasite-side DMA sequencer for Tube register 3 flyby transfers.
// Ports: clk, h_rst_b (async low); cfg_addr/cfg_count/cfg_dir captured on
// start; start/abort/irq_ack pulses; drq (async) from the Tube; outputs
// dack_b, mem_addr, dma_wr_b (PNWDS), dma_rd_b (PNRDS), busy, remaining,
// done_irq (sticky), aborted. Every output is a flop.
module tube_r3_dma_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int CNT_W          = 16,
    parameter int STB_CYCLES     = 2,
    parameter int RECOVER_CYCLES = 3
) (
    input  logic              clk,
    input  logic              h_rst_b,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              cfg_dir,
    input  logic              start,
    input  logic              abort,
    input  logic              irq_ack,
    input  logic              drq,
    output logic              dack_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              dma_wr_b,
    output logic              dma_rd_b,
    output logic              busy,
    output logic [CNT_W-1:0]  remaining,
    output logic              done_irq,
    output logic              aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_RECOVER,
        S_DONE
    } state_t;

    localparam logic [7:0]        STB_LAST = 8'(STB_CYCLES - 1);
    localparam logic [7:0]        REC_LAST = 8'(RECOVER_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t     state;
    logic       drq_m;
    logic       drq_s;
    logic       dir_q;
    logic       abort_q;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            drq_m <= 1'b0;
            drq_s <= 1'b0;
        end else begin
            drq_m <= drq;
            drq_s <= drq_m;
        end
    end

    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state     <= S_IDLE;
            dack_b    <= 1'b1;
            dma_wr_b  <= 1'b1;
            dma_rd_b  <= 1'b1;
            busy      <= 1'b0;
            done_irq  <= 1'b0;
            aborted   <= 1'b0;
            mem_addr  <= '0;
            remaining <= '0;
            dir_q     <= 1'b0;
            abort_q   <= 1'b0;
            cnt       <= '0;
        end else begin
            // Later assignment in S_DONE overrides this, so set wins.
            if (irq_ack)
                done_irq <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr  <= cfg_addr;
                        remaining <= cfg_count;
                        dir_q     <= cfg_dir;
                        aborted   <= 1'b0;
                        done_irq  <= 1'b0;
                        abort_q   <= 1'b0;
                        if (cfg_count != '0) begin
                            state <= S_WAIT;
                            busy  <= 1'b1;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (drq_s) begin
                        state  <= S_SETUP;
                        dack_b <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (abort)
                        abort_q <= 1'b1;
                    state <= S_STROBE;
                    cnt   <= '0;
                    if (dir_q)
                        dma_wr_b <= 1'b0;
                    else
                        dma_rd_b <= 1'b0;
                end
                S_STROBE: begin
                    if (abort)
                        abort_q <= 1'b1;
                    if (cnt == STB_LAST) begin
                        dma_wr_b <= 1'b1;
                        dma_rd_b <= 1'b1;
                        mem_addr <= mem_addr + ADDR_ONE;
                        if (remaining != '0)
                            remaining <= remaining - CNT_ONE;
                        state <= S_RELEASE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (abort)
                        abort_q <= 1'b1;
                    dack_b <= 1'b1;
                    cnt    <= '0;
                    state  <= S_RECOVER;
                end
                S_RECOVER: begin
                    if (abort)
                        abort_q <= 1'b1;
                    if (cnt == REC_LAST) begin
                        if (remaining == '0 || abort_q || abort) begin
                            state   <= S_DONE;
                            busy    <= 1'b0;
                            aborted <= abort_q | abort;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    done_irq <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tube_r3_dma_ctrl.sv
// Self-checking bench for tube_r3_dma_ctrl: directed scenarios plus
// randomized transfers checked against a byte-list transfer model.
module tb_tube_r3_dma_ctrl;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;
    localparam int STB    = 2;
    localparam int REC    = 3;

    logic              clk;
    logic              h_rst_b;
    logic [ADDR_W-1:0] cfg_addr;
    logic [CNT_W-1:0]  cfg_count;
    logic              cfg_dir;
    logic              start;
    logic              abort;
    logic              irq_ack;
    logic              drq;
    logic              dack_b;
    logic [ADDR_W-1:0] mem_addr;
    logic              dma_wr_b;
    logic              dma_rd_b;
    logic              busy;
    logic [CNT_W-1:0]  remaining;
    logic              done_irq;
    logic              aborted;

    tube_r3_dma_ctrl #(
        .ADDR_W(ADDR_W),
        .CNT_W(CNT_W),
        .STB_CYCLES(STB),
        .RECOVER_CYCLES(REC)
    ) dut (
        .clk(clk),
        .h_rst_b(h_rst_b),
        .cfg_addr(cfg_addr),
        .cfg_count(cfg_count),
        .cfg_dir(cfg_dir),
        .start(start),
        .abort(abort),
        .irq_ack(irq_ack),
        .drq(drq),
        .dack_b(dack_b),
        .mem_addr(mem_addr),
        .dma_wr_b(dma_wr_b),
        .dma_rd_b(dma_rd_b),
        .busy(busy),
        .remaining(remaining),
        .done_irq(done_irq),
        .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] addr;
        logic        dir;
        int          len;
    } stb_t;

    stb_t        cap[$];
    int          run_len = 0;
    logic [15:0] run_addr;
    logic        run_dir;
    int          dack_lo = 0;

    // Collect every strobe pulse as (address, direction, width).
    always @(negedge clk) begin
        if (!h_rst_b) begin
            run_len = 0;
        end else if (!dma_wr_b || !dma_rd_b) begin
            if (run_len == 0) begin
                run_addr = mem_addr;
                run_dir  = !dma_wr_b;
            end
            run_len++;
            tests++;
            assert (dack_b === 1'b0 && (dma_wr_b | dma_rd_b) === 1'b1
                    && mem_addr === run_addr)
            else begin
                fails++;
                $error("FAIL strobe_ctx observed=dack%b wr%b rd%b a%h expected=dack0 one strobe a%h",
                       dack_b, dma_wr_b, dma_rd_b, mem_addr, run_addr);
            end
        end else if (run_len > 0) begin
            cap.push_back('{run_addr, run_dir, run_len});
            run_len = 0;
        end
        if (h_rst_b && dack_b === 1'b0)
            dack_lo++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] a, input logic [15:0] n,
                               input logic d);
        cfg_addr  = a;
        cfg_count = n;
        cfg_dir   = d;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, input bit rnd);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (rnd)
                drq = ($urandom_range(0, 3) != 0);
            if (done_irq === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(ok), 32'd1);
    endtask

    task automatic ack_irq;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    // Model: byte i goes to start+i (mod 2^16), one STB-wide pulse each.
    task automatic check_xfer(input string tag, input logic [15:0] a,
                              input int n, input logic d);
        logic [15:0] ea;
        chk({tag, "_nbytes"}, 32'(cap.size()), 32'(n));
        for (int i = 0; i < n && i < cap.size(); i++) begin
            ea = a + 16'(i);
            chk($sformatf("%s_addr%0d", tag, i), 32'(cap[i].addr), 32'(ea));
            chk($sformatf("%s_dir%0d", tag, i), 32'(cap[i].dir), 32'(d));
            chk($sformatf("%s_len%0d", tag, i), 32'(cap[i].len), 32'(STB));
        end
    endtask

    initial begin
        int          lat;
        bit          hit;
        logic [15:0] ra;
        int          rn;
        logic        rd;

        h_rst_b   = 1'b0;
        cfg_addr  = '0;
        cfg_count = '0;
        cfg_dir   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        irq_ack   = 1'b0;
        drq       = 1'b0;
        repeat (3) tick();
        chk("rst_dack", 32'(dack_b), 32'd1);
        chk("rst_wr", 32'(dma_wr_b), 32'd1);
        chk("rst_rd", 32'(dma_rd_b), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(done_irq), 32'd0);
        chk("rst_abt", 32'(aborted), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_rem", 32'(remaining), 32'd0);
        h_rst_b = 1'b1;
        tick();

        // Reset in the middle of a write strobe.
        drq = 1'b1;
        pulse_start(16'h2000, 16'd4, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (dma_wr_b === 1'b0) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_reach_strobe", 32'(hit), 32'd1);
        h_rst_b = 1'b0;
        #1;
        chk("mid_dack", 32'(dack_b), 32'd1);
        chk("mid_wr", 32'(dma_wr_b), 32'd1);
        chk("mid_rd", 32'(dma_rd_b), 32'd1);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rem", 32'(remaining), 32'd0);
        tick();
        h_rst_b = 1'b1;
        repeat (10) tick();
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_dack", 32'(dack_b), 32'd1);
        cap.delete();

        // Three writes from 0x1000 with drq held high.
        dack_lo = 0;
        pulse_start(16'h1000, 16'd3, 1'b1);
        wait_done("w3", 200, 1'b0);
        check_xfer("w3", 16'h1000, 3, 1'b1);
        chk("w3_rem", 32'(remaining), 32'd0);
        chk("w3_addr", 32'(mem_addr), 32'h1003);
        chk("w3_abt", 32'(aborted), 32'd0);
        chk("w3_busy", 32'(busy), 32'd0);
        chk("w3_dacklo", 32'(dack_lo), 32'(3 * (STB + 2)));
        ack_irq();
        chk("w3_ack", 32'(done_irq), 32'd0);

        // Reads across the address wrap.
        cap.delete();
        pulse_start(16'hFFFF, 16'd2, 1'b0);
        wait_done("wrap", 200, 1'b0);
        check_xfer("wrap", 16'hFFFF, 2, 1'b0);
        chk("wrap_addr", 32'(mem_addr), 32'h0001);
        chk("wrap_rem", 32'(remaining), 32'd0);

        // Zero-length transfer.
        cap.delete();
        dack_lo = 0;
        cfg_count = '0;
        cfg_addr  = 16'h5555;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("z_irq1", 32'(done_irq), 32'd0);
        chk("z_busy", 32'(busy), 32'd0);
        tick();
        chk("z_irq2", 32'(done_irq), 32'd1);
        chk("z_abt", 32'(aborted), 32'd0);
        repeat (4) tick();
        chk("z_strobes", 32'(cap.size()), 32'd0);
        chk("z_dack", 32'(dack_lo), 32'd0);
        ack_irq();

        // Five bytes, drq gap after byte 2, abort during byte 4.
        cap.delete();
        pulse_start(16'h3000, 16'd5, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cap.size() == 2) begin
                hit = 1'b1;
                break;
            end
        end
        chk("gap_reach2", 32'(hit), 32'd1);
        drq = 1'b0;
        repeat (10) tick();
        chk("gap_dack", 32'(dack_b), 32'd1);
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_bytes", 32'(cap.size()), 32'd2);
        chk("gap_rem", 32'(remaining), 32'd3);
        drq = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (dack_b === 1'b0)
                break;
        end
        chk("resume_lat", 32'(lat), 32'd3);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cap.size() == 3 && dma_wr_b === 1'b0) begin
                hit = 1'b1;
                break;
            end
        end
        chk("abt_reach4", 32'(hit), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abt", 200, 1'b0);
        check_xfer("abt", 16'h3000, 4, 1'b1);
        chk("abt_rem", 32'(remaining), 32'd1);
        chk("abt_flag", 32'(aborted), 32'd1);
        chk("abt_addr", 32'(mem_addr), 32'h3004);
        ack_irq();

        // Start while busy; irq_ack coincident with DONE.
        cap.delete();
        pulse_start(16'h4000, 16'd2, 1'b0);
        tick();
        cfg_addr  = 16'h5000;
        cfg_count = 16'd7;
        cfg_dir   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sb_rem", 32'(remaining), 32'd2);
        chk("sb_addr", 32'(mem_addr), 32'h4000);
        chk("sb_busy", 32'(busy), 32'd1);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy === 1'b0) begin
                hit = 1'b1;
                break;
            end
        end
        chk("sb_end", 32'(hit), 32'd1);
        ack_irq();
        chk("sb_setwins", 32'(done_irq), 32'd1);
        check_xfer("sb", 16'h4000, 2, 1'b0);
        ack_irq();
        chk("sb_cleared", 32'(done_irq), 32'd0);

        // Abort in IDLE ignored; start+abort together: start wins.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abt_busy", 32'(busy), 32'd0);
        cap.delete();
        cfg_addr  = 16'h0700;
        cfg_count = 16'd1;
        cfg_dir   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        wait_done("sa", 100, 1'b0);
        check_xfer("sa", 16'h0700, 1, 1'b1);
        chk("sa_abt", 32'(aborted), 32'd0);
        ack_irq();

        // Randomized transfers with a flickering drq.
        for (int k = 0; k < 8; k++) begin
            ra = 16'($urandom);
            rn = $urandom_range(1, 6);
            rd = 1'($urandom_range(0, 1));
            cap.delete();
            drq = 1'($urandom_range(0, 1));
            pulse_start(ra, 16'(rn), rd);
            wait_done($sformatf("rnd%0d", k), 600, 1'b1);
            check_xfer($sformatf("rnd%0d", k), ra, rn, rd);
            chk($sformatf("rnd%0d_addr", k), 32'(mem_addr), 32'(16'(ra + 16'(rn))));
            chk($sformatf("rnd%0d_rem", k), 32'(remaining), 32'd0);
            chk($sformatf("rnd%0d_abt", k), 32'(aborted), 32'd0);
            ack_irq();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
